// File: rtl/nem_ohmux_bbm_seq_if.sv
// Request/data bundle for the sequenced NEM one-hot inverting mux.
// The master drives the request and channel data; the slave returns relay drive and output.
interface nem_ohmux_bbm_seq_if #(
  parameter int NIN   = 4,
  parameter int WIDTH = 8
);
  logic [NIN-1:0]       SEL_REQ;
  logic                 REQ_VLD;
  logic                 REQ_RDY;
  logic [NIN*WIDTH-1:0] I;
  logic [NIN-1:0]       S;
  logic [WIDTH-1:0]     ZN;
  logic                 ZN_VLD;
  logic                 BUSY;
  logic                 ERR;

  modport master (
    output SEL_REQ, REQ_VLD, I,
    input  REQ_RDY, S, ZN, ZN_VLD, BUSY, ERR
  );

  modport slave (
    input  SEL_REQ, REQ_VLD, I,
    output REQ_RDY, S, ZN, ZN_VLD, BUSY, ERR
  );
endinterface

// File: rtl/nem_ohmux_bbm_seq.sv
// Clocked NEM one-hot inverting mux with break-before-make relay sequencing.
// Relays are opened for BREAK_CYC cycles before a new channel closes; output is valid after MAKE_CYC.
module nem_ohmux_bbm_seq #(
  parameter int NIN       = 4,
  parameter int WIDTH     = 8,
  parameter int BREAK_CYC = 2,
  parameter int MAKE_CYC  = 3
) (
  input logic                CP,
  input logic                RST,
  nem_ohmux_bbm_seq_if.slave bus
);

  localparam int MAX_CYC = (BREAK_CYC > MAKE_CYC) ? BREAK_CYC : MAKE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] C_BREAK = CW'(BREAK_CYC);
  localparam logic [CW-1:0] C_MAKE  = CW'(MAKE_CYC);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {ST_OPEN, ST_BREAK, ST_MAKE, ST_CLOSED} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [NIN-1:0]   r_tgt, w_tgt_nxt;
  logic [NIN-1:0]   r_s, w_s_nxt;
  logic [WIDTH-1:0] r_zn, w_zn_nxt;
  logic             r_zn_vld, w_zn_vld_nxt;
  logic             r_err, w_err_nxt;

  logic             w_rdy;
  logic             w_accept;
  logic             w_multi;

  // Ready is gated by reset directly so no request can be taken while the block is held.
  assign w_rdy    = ~RST & ((r_state == ST_OPEN) | (r_state == ST_CLOSED));
  assign w_accept = bus.REQ_VLD & w_rdy;
  assign w_multi  = (bus.SEL_REQ & (bus.SEL_REQ - NIN'(1))) != '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_state  <= ST_OPEN;
      r_cnt    <= '0;
      r_tgt    <= '0;
      r_s      <= '0;
      r_zn     <= '1;
      r_zn_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tgt    <= w_tgt_nxt;
      r_s      <= w_s_nxt;
      r_zn     <= w_zn_nxt;
      r_zn_vld <= w_zn_vld_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_err_nxt   = w_accept & w_multi;
    unique case (r_state)
      ST_OPEN: begin
        if (w_accept && !w_multi && bus.SEL_REQ != '0) begin
          w_tgt_nxt   = bus.SEL_REQ;
          w_state_nxt = ST_MAKE;
          w_cnt_nxt   = C_MAKE;
        end
      end
      ST_CLOSED: begin
        if (w_accept && !w_multi && bus.SEL_REQ != r_tgt) begin
          w_tgt_nxt   = bus.SEL_REQ;
          w_state_nxt = ST_BREAK;
          w_cnt_nxt   = C_BREAK;
        end
      end
      ST_BREAK: begin
        if (r_cnt == C_ONE) begin
          // A zero target means the request was simply to open everything.
          if (r_tgt != '0) begin
            w_state_nxt = ST_MAKE;
            w_cnt_nxt   = C_MAKE;
          end else begin
            w_state_nxt = ST_OPEN;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      ST_MAKE: begin
        if (r_cnt == C_ONE) begin
          w_state_nxt = ST_CLOSED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  // Gate drive and valid follow the state being entered; ZN follows the gates already applied.
  always_comb begin
    w_s_nxt      = ((w_state_nxt == ST_MAKE) || (w_state_nxt == ST_CLOSED)) ? w_tgt_nxt : '0;
    w_zn_vld_nxt = (w_state_nxt == ST_CLOSED);
    w_zn_nxt     = '1;
    for (int k = 0; k < NIN; k++) begin
      if (r_s[k]) w_zn_nxt = w_zn_nxt & ~bus.I[k*WIDTH +: WIDTH];
    end
  end

  assign bus.REQ_RDY = w_rdy;
  assign bus.S       = r_s;
  assign bus.ZN      = r_zn;
  assign bus.ZN_VLD  = r_zn_vld;
  assign bus.BUSY    = (r_state == ST_BREAK) || (r_state == ST_MAKE);
  assign bus.ERR     = r_err;

endmodule

// File: tb/tb_nem_ohmux_bbm_seq.sv
// Directed bench for nem_ohmux_bbm_seq with NIN=4, WIDTH=8, BREAK_CYC=2, MAKE_CYC=3.
module tb_nem_ohmux_bbm_seq;

  logic CP;
  logic RST;
  int   n_tests;
  int   n_fail;

  nem_ohmux_bbm_seq_if #(.NIN(4), .WIDTH(8)) bus ();

  nem_ohmux_bbm_seq #(
    .NIN(4), .WIDTH(8), .BREAK_CYC(2), .MAKE_CYC(3)
  ) dut (
    .CP  (CP),
    .RST (RST),
    .bus (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST         = 1'b1;
    bus.SEL_REQ = '0;
    bus.REQ_VLD = 1'b0;
    bus.I       = {8'h77, 8'h3C, 8'h11, 8'hA5};

    // Reset state before any clock edge.
    #3;
    check("rst_s", 32'(bus.S), 32'h0);
    check("rst_zn", 32'(bus.ZN), 32'hFF);
    check("rst_zn_vld", 32'(bus.ZN_VLD), 32'h0);
    check("rst_rdy", 32'(bus.REQ_RDY), 32'h0);
    step();
    step();
    #3;
    RST = 1'b0;
    #1;
    check("rel_rdy", 32'(bus.REQ_RDY), 32'h1);
    check("rel_busy", 32'(bus.BUSY), 32'h0);

    // OPEN -> ch2.
    bus.SEL_REQ = 4'b0100;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    check("o2_e0_s", 32'(bus.S), 32'h4);
    check("o2_e0_busy", 32'(bus.BUSY), 32'h1);
    check("o2_e0_rdy", 32'(bus.REQ_RDY), 32'h0);
    step();
    step();
    check("o2_e2_vld", 32'(bus.ZN_VLD), 32'h0);
    step();
    check("o2_e3_vld", 32'(bus.ZN_VLD), 32'h1);
    check("o2_e3_zn", 32'(bus.ZN), 32'hC3);
    check("o2_e3_busy", 32'(bus.BUSY), 32'h0);
    check("o2_e3_rdy", 32'(bus.REQ_RDY), 32'h1);

    // CLOSED ch2 -> ch0 via break; a competing request while busy must be ignored.
    bus.SEL_REQ = 4'b0001;
    bus.REQ_VLD = 1'b1;
    step();
    check("sw_e0_s", 32'(bus.S), 32'h0);
    check("sw_e0_vld", 32'(bus.ZN_VLD), 32'h0);
    check("sw_e0_busy", 32'(bus.BUSY), 32'h1);
    check("sw_e0_rdy", 32'(bus.REQ_RDY), 32'h0);
    bus.SEL_REQ = 4'b1000;
    step();
    check("sw_e1_s", 32'(bus.S), 32'h0);
    check("sw_e1_zn", 32'(bus.ZN), 32'hFF);
    check("sw_e1_rdy", 32'(bus.REQ_RDY), 32'h0);
    step();
    check("sw_e2_s", 32'(bus.S), 32'h1);
    check("sw_e2_rdy", 32'(bus.REQ_RDY), 32'h0);
    step();
    step();
    check("sw_e4_vld", 32'(bus.ZN_VLD), 32'h0);
    step();
    bus.REQ_VLD = 1'b0;
    check("sw_e5_vld", 32'(bus.ZN_VLD), 32'h1);
    check("sw_e5_zn", 32'(bus.ZN), 32'h5A);
    check("sw_e5_s", 32'(bus.S), 32'h1);
    check("sw_e5_busy", 32'(bus.BUSY), 32'h0);

    // Multi-hot rejection.
    bus.SEL_REQ = 4'b0011;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    check("mh_err", 32'(bus.ERR), 32'h1);
    check("mh_s", 32'(bus.S), 32'h1);
    check("mh_vld", 32'(bus.ZN_VLD), 32'h1);
    check("mh_busy", 32'(bus.BUSY), 32'h0);
    step();
    check("mh_err_clr", 32'(bus.ERR), 32'h0);

    // Same-channel request is a no-op.
    bus.SEL_REQ = 4'b0001;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    check("same_busy", 32'(bus.BUSY), 32'h0);
    check("same_vld", 32'(bus.ZN_VLD), 32'h1);
    check("same_s", 32'(bus.S), 32'h1);

    // Data change appears one edge later.
    bus.I[7:0] = 8'h0F;
    #1;
    check("dat_pre", 32'(bus.ZN), 32'h5A);
    step();
    check("dat_post", 32'(bus.ZN), 32'hF0);

    // CLOSED -> open all.
    bus.SEL_REQ = 4'b0000;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    check("op_e0_s", 32'(bus.S), 32'h0);
    check("op_e0_vld", 32'(bus.ZN_VLD), 32'h0);
    check("op_e0_busy", 32'(bus.BUSY), 32'h1);
    step();
    check("op_e1_busy", 32'(bus.BUSY), 32'h1);
    check("op_e1_zn", 32'(bus.ZN), 32'hFF);
    step();
    check("op_e2_busy", 32'(bus.BUSY), 32'h0);
    check("op_e2_rdy", 32'(bus.REQ_RDY), 32'h1);
    check("op_e2_zn", 32'(bus.ZN), 32'hFF);
    check("op_e2_s", 32'(bus.S), 32'h0);

    // Zero request while OPEN is a no-op.
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    check("oz_busy", 32'(bus.BUSY), 32'h0);
    check("oz_s", 32'(bus.S), 32'h0);

    // Close ch2, then switch to ch1 and reset mid-MAKE.
    bus.SEL_REQ = 4'b0100;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    step();
    step();
    step();
    check("rm_closed", 32'(bus.ZN_VLD), 32'h1);
    bus.SEL_REQ = 4'b0010;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    step();
    step();
    check("rm_make_s", 32'(bus.S), 32'h2);
    step();
    check("rm_e3_busy", 32'(bus.BUSY), 32'h1);
    #3;
    RST = 1'b1;
    #1;
    check("rm_s", 32'(bus.S), 32'h0);
    check("rm_zn", 32'(bus.ZN), 32'hFF);
    check("rm_vld", 32'(bus.ZN_VLD), 32'h0);
    check("rm_busy", 32'(bus.BUSY), 32'h0);
    check("rm_rdy", 32'(bus.REQ_RDY), 32'h0);
    RST = 1'b0;
    #1;
    check("rm_rel_rdy", 32'(bus.REQ_RDY), 32'h1);

    // Fresh request from OPEN completes in MAKE_CYC edges.
    bus.SEL_REQ = 4'b1000;
    bus.REQ_VLD = 1'b1;
    step();
    bus.REQ_VLD = 1'b0;
    check("ch3_e0_s", 32'(bus.S), 32'h8);
    step();
    step();
    check("ch3_e2_vld", 32'(bus.ZN_VLD), 32'h0);
    step();
    check("ch3_e3_vld", 32'(bus.ZN_VLD), 32'h1);
    check("ch3_e3_zn", 32'(bus.ZN), 32'h88);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
